// File: rtl/nibble_serial_cla_subtractor_if.sv
// Operand/result handshake bundle for nibble_serial_cla_subtractor.
// SUB_ADD_MODE_EN adds the op select (0 = subtract, 1 = add).
interface nibble_serial_cla_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
`ifdef SUB_ADD_MODE_EN
    logic             op;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;
    logic             busy;

`ifdef SUB_ADD_MODE_EN
    modport master (
        output in_valid, a, b, bin, op, out_ready,
        input  in_ready, out_valid, diff, bout, overflow, busy
    );
    modport slave (
        input  in_valid, a, b, bin, op, out_ready,
        output in_ready, out_valid, diff, bout, overflow, busy
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, overflow, busy
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, overflow, busy
    );
`endif
endinterface

// File: rtl/nibble_serial_cla_subtractor.sv
// Serial A - B - Bin, one 4-bit carry-lookahead slice per clock behind valid/ready.
// SUB_ADD_MODE_EN: adds op input; op=1 computes A + B + Bin instead.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | computing slice k, busy=1
// DONE  | result held, out_valid=1 until out_ready
module nibble_serial_cla_subtractor #(
    parameter int WIDTH = 32
) (
    input logic                           clk,
    input logic                           rst_n,
    nibble_serial_cla_subtractor_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [KW-1:0]    k;
    logic             c;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;
    logic             op_r;
    logic             op_in;
    logic             accept;
    logic             last;

    logic [KW+1:0]    base;
    logic [3:0]       sa;
    logic [3:0]       sb;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       cc;
    logic [3:0]       sum;
    logic             grp_g;
    logic             grp_p;
    logic [WIDTH-1:0] diff_nxt;
    logic             ovf_nxt;

`ifdef SUB_ADD_MODE_EN
    assign op_in = bus.op;
`else
    assign op_in = 1'b0;
`endif

    assign accept = bus.in_valid & bus.in_ready;
    assign last   = (k == KW'(N - 1));

    // Slice k: B is inverted for subtraction so the borrow chain becomes a carry chain.
    always_comb begin
        base  = {k, 2'b00};
        sa    = a_r[base +: 4];
        sb    = op_r ? b_r[base +: 4] : ~b_r[base +: 4];
        g     = sa & sb;
        p     = sa | sb;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        cc[0] = c;
        cc[1] = g[0] | (p[0] & c);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        cc[4] = grp_g | (grp_p & c);
        sum   = sa ^ sb ^ cc[3:0];
        diff_nxt = diff_r;
        diff_nxt[base +: 4] = sum;
        if (op_r)
            ovf_nxt = ~(a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ diff_nxt[WIDTH-1]);
        else
            ovf_nxt = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ diff_nxt[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            c      <= 1'b0;
            k      <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            op_r   <= op_in;
            c      <= op_in ? bus.bin : ~bus.bin;
            k      <= '0;
            diff_r <= '0;
        end else if (state == RUN) begin
            diff_r <= diff_nxt;
            c      <= cc[4];
            if (last) begin
                k      <= '0;
                bout_r <= op_r ? cc[4] : ~cc[4];
                ovf_r  <= ovf_nxt;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign bus.diff     = diff_r;
    assign bus.bout     = bout_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_nibble_serial_cla_subtractor.sv
// Directed bench for nibble_serial_cla_subtractor with a result scoreboard queue.
module tb_nibble_serial_cla_subtractor;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t q[$];
    exp_t e_bp;
    exp_t e_last;

    nibble_serial_cla_subtractor_if #(.WIDTH(W)) bus ();

    nibble_serial_cla_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, input logic op);
        logic [W:0] f;
        exp_t       e;
        if (op) begin
            f    = {1'b0, a} + {1'b0, b} + (W+1)'(bin);
            e.ov = ~(a[W-1] ^ b[W-1]) & (a[W-1] ^ f[W-1]);
        end else begin
            f    = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
            e.ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ f[W-1]);
        end
        e.d  = f[W-1:0];
        e.bo = f[W];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bin, input logic op);
        bus.a   = a;
        bus.b   = b;
        bus.bin = bin;
`ifdef SUB_ADD_MODE_EN
        bus.op  = op;
`endif
        if (op) begin end
    endtask

    // Drive operands, wait for acceptance, then scramble the inputs.
    task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic op);
        int n;
        n = 0;
        drive_ops(a, b, bin, op);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk({tag, "_accept_timeout"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        drive_ops($urandom, $urandom, 1'($urandom), 1'b0);
        q.push_back(model(a, b, bin, op));
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        if (exp_lat > 0) chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        chk({tag, "_sb_empty"}, 64'(q.size() == 0), 64'd0);
        if (q.size() != 0) begin
            e = q[0];
            chk({tag, "_diff"}, 64'(bus.diff), 64'(e.d));
            chk({tag, "_bout"}, 64'(bus.bout), 64'(e.bo));
            chk({tag, "_ovf"}, 64'(bus.overflow), 64'(e.ov));
        end
    endtask

    task automatic take(input string tag);
        compare_head(tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        if (q.size() != 0) e_last = q.pop_front();
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic op);
        send(tag, a, b, bin, op);
        wait_result(tag, 8);
        take(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_diff", 64'(bus.diff), 64'd0);
        chk("rst_bout", 64'(bus.bout), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        run_op("sub_5_3", 32'd5, 32'd3, 1'b0, 1'b0);
        run_op("sub_0_1", 32'd0, 32'd1, 1'b0, 1'b0);
        run_op("sub_7_7_b1", 32'd7, 32'd7, 1'b1, 1'b0);
        run_op("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 1'b0);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Backpressure, then back-to-back accept in the handshake cycle.
        send("bp", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
        wait_result("bp", 8);
        e_bp = q[0];
        for (int i = 0; i < 5; i++) begin
            chk("bp_diff_hold", 64'(bus.diff), 64'(e_bp.d));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            tick();
        end
        compare_head("bp");
        drive_ops(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b1, 1'b0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(model(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b1, 1'b0));
        drive_ops($urandom, $urandom, 1'b0, 1'b0);
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        wait_result("b2b", 8);
        take("b2b");
        chk("idle_diff_hold", 64'(bus.diff), 64'(e_last.d));
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset while RUN is at k=3.
        drive_ops(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_diff", 64'(bus.diff), 64'd0);
        chk("mid_rst_bout", 64'(bus.bout), 64'd0);
        chk("mid_rst_ovf", 64'(bus.overflow), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
        run_op("sub_9_4", 32'd9, 32'd4, 1'b0, 1'b0);

`ifdef SUB_ADD_MODE_EN
        run_op("add_carry", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 4; i++) begin
            run_op("rand", $urandom, $urandom, 1'($urandom), 1'b0);
        end

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
